rf_write_controller: RTL and testbench

- Write-side controller for the 16 x 16-bit register file; it is the producer that drives the file's write port and consumes its two read ports.
- Buffers writeback requests from the WB stage in a small in-order queue.
- Retires at most one queued write per cycle onto WriteReg/DstReg/DstData, and gives a debug/loader port priority over the queue.
- Forwards not-yet-retired data onto both read paths, so decode always sees the newest value.

---
 rtl/rf_ctrl_pkg.sv | 11 +
 rtl/rf_wb_queue.sv | 63 ++++++
 rtl/rf_write_controller.sv | 104 ++++++++++
 tb/tb_rf_write_controller.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/rf_ctrl_pkg.sv
// Shared widths and the queued-write record for the register-file write controller.
package rf_ctrl_pkg;
  localparam int REG_ADDR_W = 4;
  localparam int DATA_W     = 16;

  // "reg" is a keyword, so the destination field is named dst.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] dst;
    logic [DATA_W-1:0]     data;
  } rf_wr_t;
endpackage

// File: rtl/rf_wb_queue.sv
// In-order circular writeback queue; exposes every slot with valid/age for forwarding.
module rf_wb_queue
  import rf_ctrl_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push_i,
  input  rf_wr_t                        push_data_i,
  input  logic                          pop_i,
  output rf_wr_t                        head_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [CNT_W-1:0]              occupancy_o,
  output rf_wr_t [DEPTH-1:0]            ent_o,
  output logic [DEPTH-1:0]              valid_o,
  output logic [DEPTH-1:0][PTR_W-1:0]   age_o
);
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  rf_wr_t [DEPTH-1:0] mem_q;

  // The owner never pushes when full nor pops when empty.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push_i);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_i);
    count_d  = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o      = mem_q[rd_ptr_q];
  assign full_o      = (count_q == CNT_W'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign occupancy_o = count_q;
  assign ent_o       = mem_q;

  // Age 0 is the head; a slot is live when its age is below the count.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      age_o[i]   = PTR_W'(i) - rd_ptr_q;
      valid_o[i] = ({1'b0, age_o[i]} < count_q);
    end
  end
endmodule

// File: rtl/rf_write_controller.sv
// Drives the register-file write port from a writeback queue (debug port wins)
// and forwards not-yet-retired queue data onto both read paths.
module rf_write_controller
  import rf_ctrl_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter bit DROP_R0 = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wb_valid,
  output logic                      wb_ready,
  input  logic [3:0]                wb_reg,
  input  logic [15:0]               wb_data,
  input  logic                      dbg_we,
  input  logic [3:0]                dbg_reg,
  input  logic [15:0]               dbg_data,
  output logic                      WriteReg,
  output logic [3:0]                DstReg,
  output logic [15:0]               DstData,
  input  logic [3:0]                SrcReg1,
  input  logic [3:0]                SrcReg2,
  input  logic [15:0]               RfData1,
  input  logic [15:0]               RfData2,
  output logic [15:0]               SrcData1,
  output logic [15:0]               SrcData2,
  output logic [$clog2(DEPTH):0]    occupancy
);
  localparam int PTR_W = $clog2(DEPTH);

  logic                          q_push, q_pop, q_full, q_empty;
  rf_wr_t                        q_head;
  rf_wr_t [DEPTH-1:0]            q_ent;
  logic [DEPTH-1:0]              q_valid;
  logic [DEPTH-1:0][PTR_W-1:0]   q_age;

  rf_wb_queue #(.DEPTH(DEPTH)) u_queue (
    .clk         (clk),
    .rst         (rst),
    .push_i      (q_push),
    .push_data_i ({wb_reg, wb_data}),
    .pop_i       (q_pop),
    .head_o      (q_head),
    .full_o      (q_full),
    .empty_o     (q_empty),
    .occupancy_o (occupancy),
    .ent_o       (q_ent),
    .valid_o     (q_valid),
    .age_o       (q_age)
  );

  // Ready comes from the registered count only, so a full queue never pops through.
  assign wb_ready = !q_full;
  assign q_push   = wb_valid && wb_ready && !rst && !(DROP_R0 && (wb_reg == '0));

  always_comb begin
    WriteReg = 1'b0;
    DstReg   = '0;
    DstData  = '0;
    q_pop    = 1'b0;
    if (!rst) begin
      if (dbg_we) begin
        WriteReg = 1'b1;
        DstReg   = dbg_reg;
        DstData  = dbg_data;
      end else if (!q_empty) begin
        WriteReg = 1'b1;
        DstReg   = q_head.dst;
        DstData  = q_head.data;
        q_pop    = 1'b1;
      end
    end
  end

  // Youngest live match wins; the head is still searched since it is not yet in the file.
  function automatic logic [DATA_W-1:0] fwd(
    input logic [REG_ADDR_W-1:0]        addr,
    input logic [DATA_W-1:0]            raw,
    input rf_wr_t [DEPTH-1:0]           ent,
    input logic [DEPTH-1:0]             vld,
    input logic [DEPTH-1:0][PTR_W-1:0]  age
  );
    logic [DATA_W-1:0] d;
    logic              hit;
    logic [PTR_W-1:0]  best;
    d    = raw;
    hit  = 1'b0;
    best = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && (ent[i].dst == addr) && (!hit || (age[i] > best))) begin
        d    = ent[i].data;
        best = age[i];
        hit  = 1'b1;
      end
    end
    if (DROP_R0 && (addr == '0)) d = '0;
    return d;
  endfunction

  always_comb begin
    SrcData1 = fwd(SrcReg1, RfData1, q_ent, q_valid, q_age);
    SrcData2 = fwd(SrcReg2, RfData2, q_ent, q_valid, q_age);
  end
endmodule

// File: tb/tb_rf_write_controller.sv
// Bench for rf_write_controller: queue-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_rf_write_controller;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_valid = 1'b0, dbg_we = 1'b0;
  logic [3:0]  wb_reg = '0, dbg_reg = '0, SrcReg1 = '0, SrcReg2 = '0;
  logic [15:0] wb_data = '0, dbg_data = '0, RfData1 = '0, RfData2 = '0;
  logic        wb_ready, WriteReg;
  logic [3:0]  DstReg;
  logic [15:0] DstData, SrcData1, SrcData2;
  logic [2:0]  occupancy;

  rf_write_controller #(.DEPTH(DEPTH), .DROP_R0(1'b1)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_reg(wb_reg), .wb_data(wb_data),
    .dbg_we(dbg_we), .dbg_reg(dbg_reg), .dbg_data(dbg_data),
    .WriteReg(WriteReg), .DstReg(DstReg), .DstData(DstData),
    .SrcReg1(SrcReg1), .SrcReg2(SrcReg2), .RfData1(RfData1), .RfData2(RfData2),
    .SrcData1(SrcData1), .SrcData2(SrcData2), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  r;
    logic [15:0] d;
  } ent_t;

  ent_t mq[$];
  ent_t wlog[$];
  int   nvec = 0;
  int   nerr = 0;
  bit   check_en = 1'b0;
  bit   log_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_fwd(input logic [3:0] a, input logic [15:0] raw);
    if (a == 4'd0) return 16'h0000;
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].r == a) return mq[i].d;
    return raw;
  endfunction

  // Reference model: state advances at the edge from the inputs held before it.
  always @(posedge clk) begin
    bit rdy;
    rdy = (mq.size() < DEPTH);
    if (rst) mq.delete();
    else begin
      if (!dbg_we && mq.size() > 0) void'(mq.pop_front());
      if (wb_valid && rdy && wb_reg != 4'd0) mq.push_back('{wb_reg, wb_data});
    end
  end

  always @(negedge clk) begin
    logic        e_we;
    logic [3:0]  e_reg;
    logic [15:0] e_dat;
    if (check_en) begin
      e_we = 1'b0; e_reg = '0; e_dat = '0;
      if (!rst && dbg_we) begin
        e_we = 1'b1; e_reg = dbg_reg; e_dat = dbg_data;
      end else if (!rst && mq.size() > 0) begin
        e_we = 1'b1; e_reg = mq[0].r; e_dat = mq[0].d;
      end
      chk("WriteReg", 32'(WriteReg), 32'(e_we));
      chk("DstReg", 32'(DstReg), 32'(e_reg));
      chk("DstData", 32'(DstData), 32'(e_dat));
      chk("wb_ready", 32'(wb_ready), 32'(mq.size() < DEPTH));
      chk("occupancy", 32'(occupancy), 32'(mq.size()));
      chk("SrcData1", 32'(SrcData1), 32'(model_fwd(SrcReg1, RfData1)));
      chk("SrcData2", 32'(SrcData2), 32'(model_fwd(SrcReg2, RfData2)));
    end
    if (log_en && WriteReg && !dbg_we) wlog.push_back('{DstReg, DstData});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] r, input logic [15:0] d);
    bit ok;
    ok = 1'b0;
    wb_valid = 1'b1; wb_reg = r; wb_data = d;
    for (int n = 0; n < 20 && !ok; n++) begin
      ok = wb_ready;
      step();
    end
    wb_valid = 1'b0;
    chk("push_handshake", 32'(ok), 32'd1);
  endtask

  initial begin
    ent_t exp_order[5];
    exp_order[0] = '{4'd1, 16'h0001};
    exp_order[1] = '{4'd1, 16'h0002};
    exp_order[2] = '{4'd2, 16'h0003};
    exp_order[3] = '{4'd4, 16'h0004};
    exp_order[4] = '{4'd5, 16'h0005};

    step();
    check_en = 1'b1;
    step();
    rst = 1'b0;

    // Idle after reset
    SrcReg1 = 4'd5; RfData1 = 16'hA5A5;
    step();
    chk("idle_we", 32'(WriteReg), 32'd0);
    chk("idle_ready", 32'(wb_ready), 32'd1);
    chk("idle_occ", 32'(occupancy), 32'd0);
    chk("idle_src1", 32'(SrcData1), 32'hA5A5);

    // Single push, one-cycle latency, forwarded while pending
    push(4'd3, 16'hBEEF);
    SrcReg1 = 4'd3; RfData1 = 16'h0000;
    #1;
    chk("lat_we", 32'(WriteReg), 32'd1);
    chk("lat_reg", 32'(DstReg), 32'd3);
    chk("lat_data", 32'(DstData), 32'hBEEF);
    chk("lat_fwd", 32'(SrcData1), 32'hBEEF);
    step();
    chk("lat_empty", 32'(occupancy), 32'd0);

    // Debug priority holds the queue; fill, stall, ordering, youngest forward
    dbg_we = 1'b1; dbg_reg = 4'd9; dbg_data = 16'h9999;
    push(4'd1, 16'h0001);
    push(4'd1, 16'h0002);
    push(4'd2, 16'h0003);
    push(4'd4, 16'h0004);
    wb_valid = 1'b1; wb_reg = 4'd5; wb_data = 16'h0005;
    step();
    step();
    chk("full_ready", 32'(wb_ready), 32'd0);
    chk("full_occ", 32'(occupancy), 32'd4);
    SrcReg1 = 4'd1; RfData1 = 16'h7777;
    #1;
    chk("youngest_fwd", 32'(SrcData1), 32'h0002);
    wlog.delete();
    log_en = 1'b1;
    dbg_we = 1'b0;
    step();
    step();
    wb_valid = 1'b0;
    repeat (6) step();
    log_en = 1'b0;
    chk("order_count", 32'(wlog.size()), 32'd5);
    for (int i = 0; i < 5 && i < wlog.size(); i++) begin
      chk("order_reg", 32'(wlog[i].r), 32'(exp_order[i].r));
      chk("order_data", 32'(wlog[i].d), 32'(exp_order[i].d));
    end

    // Register 0 is handshaken and discarded
    push(4'd0, 16'h1234);
    SrcReg2 = 4'd0; RfData2 = 16'hFFFF;
    #1;
    chk("r0_we", 32'(WriteReg), 32'd0);
    chk("r0_occ", 32'(occupancy), 32'd0);
    chk("r0_src2", 32'(SrcData2), 32'h0000);

    // Full with simultaneous pop: no accept that edge, accepted at the next
    dbg_we = 1'b1;
    push(4'd10, 16'h00A0);
    push(4'd11, 16'h00B0);
    push(4'd12, 16'h00C0);
    push(4'd13, 16'h00D0);
    chk("fp_occ_full", 32'(occupancy), 32'd4);
    wb_valid = 1'b1; wb_reg = 4'd7; wb_data = 16'h0077;
    dbg_we = 1'b0;
    #1;
    chk("fp_ready", 32'(wb_ready), 32'd0);
    step();
    chk("fp_occ_pop", 32'(occupancy), 32'd3);
    dbg_we = 1'b1;
    step();
    wb_valid = 1'b0;
    chk("fp_occ_back", 32'(occupancy), 32'd4);
    dbg_we = 1'b0;
    repeat (6) step();

    // Reset with pending entries discards them
    dbg_we = 1'b1;
    push(4'd6, 16'h6666);
    push(4'd7, 16'h7070);
    push(4'd8, 16'h8888);
    chk("rst_pending", 32'(occupancy), 32'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    dbg_we = 1'b0;
    wlog.delete();
    log_en = 1'b1;
    #1;
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_we", 32'(WriteReg), 32'd0);
    repeat (3) step();
    log_en = 1'b0;
    chk("rst_no_write", 32'(wlog.size()), 32'd0);

    // Mixed traffic under the per-cycle model comparison
    for (int c = 0; c < 80; c++) begin
      wb_valid = ($urandom_range(0, 2) != 0);
      wb_reg   = 4'($urandom_range(0, 15));
      wb_data  = 16'($urandom);
      dbg_we   = ($urandom_range(0, 4) == 0);
      dbg_reg  = 4'($urandom_range(0, 15));
      dbg_data = 16'($urandom);
      SrcReg1  = 4'($urandom_range(0, 15));
      SrcReg2  = 4'($urandom_range(0, 15));
      RfData1  = 16'($urandom);
      RfData2  = 16'($urandom);
      rst      = ($urandom_range(0, 39) == 0);
      step();
    end
    rst = 1'b0; wb_valid = 1'b0; dbg_we = 1'b0;
    repeat (6) step();

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
